// File: rtl/step_clock_controller.sv
// Processor clock source: debounced single-step pulses or a free-running divider,
// gated by halt, with a rising-edge strobe and a wrapping edge counter.
module step_clock_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 25,
    parameter int RUN_DIVIDER     = 25000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button_in,
    input  logic        run_mode,
    input  logic        halt,
    output logic        cpu_clock,
    output logic        step_pulse,
    output logic [31:0] step_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PC_MAX = (PULSE_CYCLES > RUN_DIVIDER) ? PULSE_CYCLES : RUN_DIVIDER;
    localparam int PC_W   = $clog2(PC_MAX + 1);

    localparam logic [DB_W-1:0] DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam bit              DB_SINGLE = (DEBOUNCE_CYCLES == 1);
    localparam logic [PC_W-1:0] PC_ONE    = PC_W'(1);
    localparam logic [PC_W-1:0] PC_STEP   = PC_W'(PULSE_CYCLES);
    localparam logic [PC_W-1:0] PC_RUN    = PC_W'(RUN_DIVIDER);

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_t;

    typedef enum logic {
        GEN_LOW,
        GEN_HIGH
    } gen_state_t;

    logic            r_sync1;
    logic            r_sync2;
    db_state_t       r_db_state;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_press_accept;

    gen_state_t      r_gen_state;
    logic [PC_W-1:0] r_pc_cnt;
    logic            r_mode_hi;
    logic            r_cpu_clock;
    logic            r_step_pulse;
    logic [31:0]     r_step_count;

    logic            w_run_due;
    logic            w_rise;
    logic [PC_W-1:0] w_hi_limit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: a press or release must hold for DEBOUNCE_CYCLES consecutive samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_db_state     <= DB_IDLE;
            r_db_cnt       <= '0;
            r_press_accept <= 1'b0;
        end else begin
            r_press_accept <= 1'b0;
            case (r_db_state)
                DB_IDLE: begin
                    if (r_sync2) begin
                        if (DB_SINGLE) begin
                            r_db_state     <= DB_HELD;
                            r_db_cnt       <= '0;
                            r_press_accept <= 1'b1;
                        end else begin
                            r_db_state <= DB_PRESS_WAIT;
                            r_db_cnt   <= DB_ONE;
                        end
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_db_state <= DB_IDLE;
                        r_db_cnt   <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state     <= DB_HELD;
                        r_db_cnt       <= '0;
                        r_press_accept <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                DB_HELD: begin
                    if (!r_sync2) begin
                        if (DB_SINGLE) begin
                            r_db_state <= DB_IDLE;
                            r_db_cnt   <= '0;
                        end else begin
                            r_db_state <= DB_RELEASE_WAIT;
                            r_db_cnt   <= DB_ONE;
                        end
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_db_state <= DB_HELD;
                        r_db_cnt   <= '0;
                    end else if (r_db_cnt == DB_LAST) begin
                        r_db_state <= DB_IDLE;
                        r_db_cnt   <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + DB_ONE;
                    end
                end
                default: begin
                    r_db_state <= DB_IDLE;
                    r_db_cnt   <= '0;
                end
            endcase
        end
    end

    // In LOW the phase counter saturates at RUN_DIVIDER, so a halted run resumes on the next edge.
    assign w_run_due  = (r_pc_cnt >= PC_RUN);
    assign w_rise     = (r_gen_state == GEN_LOW) && !halt && (run_mode ? w_run_due : r_press_accept);
    assign w_hi_limit = r_mode_hi ? PC_RUN : PC_STEP;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_gen_state  <= GEN_LOW;
            r_pc_cnt     <= '0;
            r_mode_hi    <= 1'b0;
            r_cpu_clock  <= 1'b0;
            r_step_pulse <= 1'b0;
            r_step_count <= '0;
        end else begin
            r_step_pulse <= w_rise;
            case (r_gen_state)
                GEN_LOW: begin
                    if (w_rise) begin
                        r_gen_state  <= GEN_HIGH;
                        r_pc_cnt     <= PC_ONE;
                        r_mode_hi    <= run_mode;
                        r_cpu_clock  <= 1'b1;
                        r_step_count <= r_step_count + 32'd1;
                    end else if (!w_run_due) begin
                        r_pc_cnt <= r_pc_cnt + PC_ONE;
                    end
                end
                GEN_HIGH: begin
                    // halt is ignored here: a started high phase always runs to length.
                    if (r_pc_cnt >= w_hi_limit) begin
                        r_gen_state <= GEN_LOW;
                        r_pc_cnt    <= PC_ONE;
                        r_cpu_clock <= 1'b0;
                    end else begin
                        r_pc_cnt <= r_pc_cnt + PC_ONE;
                    end
                end
                default: begin
                    r_gen_state <= GEN_LOW;
                    r_cpu_clock <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_clock  = r_cpu_clock;
    assign step_pulse = r_step_pulse;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_step_clock_controller.sv
// Bench for step_clock_controller: expected rising edges are queued with their
// cycle number and count, then matched against each observed step_pulse.
module tb_step_clock_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        button_in = 1'b0;
    logic        run_mode = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_clock;
    logic        step_pulse;
    logic [31:0] step_count;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned k;

    typedef struct {
        int unsigned cyc;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    step_clock_controller #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (3),
        .RUN_DIVIDER    (2)
    ) dut (
        .clock     (clk),
        .reset     (reset),
        .button_in (button_in),
        .run_mode  (run_mode),
        .halt      (halt),
        .cpu_clock (cpu_clock),
        .step_pulse(step_pulse),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_pulse(input int unsigned c, input logic [31:0] cnt);
        exp_t e;
        e.cyc = c;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        button_in = 1'b0;
        run_mode  = 1'b0;
        halt      = 1'b0;
        tick(1);
        check_eq("rst_cpu_clock", {31'b0, cpu_clock}, 32'd0);
        check_eq("rst_step_pulse", {31'b0, step_pulse}, 32'd0);
        check_eq("rst_step_count", step_count, 32'd0);
        tick(1);
        reset = 1'b0;
        tick(4);
    endtask

    // Scoreboard side: every observed strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (step_pulse) begin
            check_eq("pulse_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("pulse at cycle %0d count %0d (expected cycle %0d count %0d)",
                         cyc, step_count, e.cyc, e.cnt);
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("pulse_count", step_count, e.cnt);
            end
        end
    end

    initial begin
        // 1: clean press, button held 20 cycles
        apply_reset();
        k = cyc;
        button_in = 1'b1;
        push_pulse(k + 7, 32'd1);
        for (int e = 0; e < 20; e++) begin
            tick(1);
            check_eq("t1_cpu_clock", {31'b0, cpu_clock}, {31'b0, (e >= 6 && e <= 8)});
            check_eq("t1_step_pulse", {31'b0, step_pulse}, {31'b0, (e == 6)});
        end
        button_in = 1'b0;
        tick(12);
        check_eq("t1_step_count", step_count, 32'd1);

        // 2: bounce 1,1,0,1,1,0 then held
        apply_reset();
        begin
            logic [6:0] pat;
            pat = 7'b1011011;
            k = cyc;
            push_pulse(k + 13, 32'd1);
            for (int i = 0; i < 7; i++) begin
                button_in = pat[i];
                tick(1);
            end
        end
        tick(19);
        button_in = 1'b0;
        tick(12);
        check_eq("t2_step_count", step_count, 32'd1);

        // 3: free-run for 40 cycles
        apply_reset();
        k = cyc;
        run_mode = 1'b1;
        for (int n = 0; n < 10; n++) push_pulse(k + 1 + 4 * n, 32'(n + 1));
        for (int e = 1; e <= 40; e++) begin
            tick(1);
            check_eq("t3_cpu_clock", {31'b0, cpu_clock}, {31'b0, ((e - 1) % 4) < 2});
        end
        run_mode = 1'b0;
        tick(6);
        check_eq("t3_step_count", step_count, 32'd10);

        // 4: halt during HIGH, resume, press while halted
        apply_reset();
        k = cyc;
        run_mode = 1'b1;
        push_pulse(k + 1, 32'd1);
        push_pulse(k + 5, 32'd2);
        tick(5);
        halt = 1'b1;
        for (int e = 6; e <= 20; e++) begin
            tick(1);
            check_eq("t4_halt_cpu_clock", {31'b0, cpu_clock}, {31'b0, (e == 6)});
        end
        check_eq("t4_halt_count", step_count, 32'd2);
        halt = 1'b0;
        push_pulse(k + 21, 32'd3);
        push_pulse(k + 25, 32'd4);
        tick(1);
        check_eq("t4_resume_cpu_clock", {31'b0, cpu_clock}, 32'd1);
        tick(5);
        run_mode = 1'b0;
        halt = 1'b1;
        tick(2);
        button_in = 1'b1;
        tick(15);
        button_in = 1'b0;
        tick(15);
        check_eq("t4_press_halted_clk", {31'b0, cpu_clock}, 32'd0);
        check_eq("t4_press_halted_count", step_count, 32'd4);
        halt = 1'b0;
        tick(6);
        check_eq("t4_no_queued_press", step_count, 32'd4);

        // 5: wrap, then reset mid-HIGH
        apply_reset();
        force dut.r_step_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_step_count;
        check_eq("t5_forced_count", step_count, 32'hFFFF_FFFF);
        k = cyc;
        button_in = 1'b1;
        push_pulse(k + 7, 32'd0);
        tick(8);
        check_eq("t5_wrap_count", step_count, 32'd0);
        button_in = 1'b0;
        tick(12);
        k = cyc;
        button_in = 1'b1;
        push_pulse(k + 7, 32'd1);
        tick(7);
        check_eq("t5_high_before_reset", {31'b0, cpu_clock}, 32'd1);
        reset = 1'b1;
        button_in = 1'b0;
        tick(1);
        check_eq("t5_reset_cpu_clock", {31'b0, cpu_clock}, 32'd0);
        check_eq("t5_reset_step_count", step_count, 32'd0);
        check_eq("t5_reset_step_pulse", {31'b0, step_pulse}, 32'd0);
        reset = 1'b0;
        tick(10);
        check_eq("t5_idle_after_reset", step_count, 32'd0);

        check_eq("pulses_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
